// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: a DEPTH-entry circular buffer with a valid/ready handshake,
// flush-to-bubble and an occupancy count for hazard logic.
module pipe_stage_elastic #(
  parameter int unsigned DATA_W = 153,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_FLUSH,
  input  logic              I_VALID,
  output logic              O_READY,
  input  logic [DATA_W-1:0] I_DATA,
  output logic              O_VALID,
  input  logic              I_READY,
  output logic [DATA_W-1:0] O_DATA,
  output logic [CNT_W-1:0]  O_COUNT
);

  localparam int unsigned      PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0]  LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push;
  logic              pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    O_READY = (count_q < FullCnt);
    O_VALID = (count_q != '0);
    O_COUNT = count_q;
    O_DATA  = O_VALID ? mem_q[rd_ptr_q] : '0;
    push    = I_VALID && O_READY;
    pop     = O_VALID && I_READY;
  end

  always_ff @(posedge CLK) begin
    if (RESET || I_FLUSH) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage is not reset; count gates what is visible.
  always_ff @(posedge CLK) begin
    if (!RESET && !I_FLUSH && push) begin
      mem_q[wr_ptr_q] <= I_DATA;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomised and directed bench for pipe_stage_elastic: DEPTH=2 and DEPTH=3 instances checked
// every cycle against queue-based reference models.
module tb_pipe_stage_elastic;

  localparam int DW = 153;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default DEPTH=2.
  logic          a_rst, a_flush, a_vld, a_rdy, a_ordy, a_ovld;
  logic [DW-1:0] a_data, a_odata;
  logic [1:0]    a_cnt;
  // Instance B: DEPTH=3.
  logic          b_rst, b_flush, b_vld, b_rdy, b_ordy, b_ovld;
  logic [DW-1:0] b_data, b_odata;
  logic [1:0]    b_cnt;

  pipe_stage_elastic #(.DATA_W(DW), .DEPTH(2)) dut_a (
    .CLK(clk), .RESET(a_rst), .I_FLUSH(a_flush), .I_VALID(a_vld), .O_READY(a_ordy),
    .I_DATA(a_data), .O_VALID(a_ovld), .I_READY(a_rdy), .O_DATA(a_odata), .O_COUNT(a_cnt)
  );

  pipe_stage_elastic #(.DATA_W(DW), .DEPTH(3)) dut_b (
    .CLK(clk), .RESET(b_rst), .I_FLUSH(b_flush), .I_VALID(b_vld), .O_READY(b_ordy),
    .I_DATA(b_data), .O_VALID(b_ovld), .I_READY(b_rdy), .O_DATA(b_odata), .O_COUNT(b_cnt)
  );

  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [DW-1:0] b_seen[$];
  int n_checks = 0;
  int n_pass   = 0;
  int b_pushed = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // Reference: the stage is a bounded FIFO; full refuses pushes regardless of a same-cycle pop.
  task automatic model_edge(input int depth, input logic rst, input logic flush, input logic vld,
                            input logic rdy, input logic [DW-1:0] din,
                            inout logic [DW-1:0] q[$], output bit pushed);
    bit do_push, do_pop;
    pushed = 0;
    if (rst || flush) begin
      q.delete();
    end else begin
      do_push = vld && (q.size() < depth);
      do_pop  = rdy && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(din);
      pushed = do_push;
    end
  endtask

  task automatic check_outputs();
    check("a_valid", DW'(a_ovld), DW'(qa.size() != 0));
    check("a_ready", DW'(a_ordy), DW'(qa.size() < 2));
    check("a_count", DW'(a_cnt), DW'(qa.size()));
    check("a_data", a_odata, (qa.size() != 0) ? qa[0] : '0);
    check("b_valid", DW'(b_ovld), DW'(qb.size() != 0));
    check("b_ready", DW'(b_ordy), DW'(qb.size() < 3));
    check("b_count", DW'(b_cnt), DW'(qb.size()));
    check("b_data", b_odata, (qb.size() != 0) ? qb[0] : '0);
  endtask

  // One clock: record B's handshakes from the DUT, advance models, then check #1 after the edge.
  task automatic cycle();
    bit pa, pb;
    if (!b_rst && !b_flush && b_ovld && b_rdy) b_seen.push_back(b_odata);
    @(posedge clk);
    model_edge(2, a_rst, a_flush, a_vld, a_rdy, a_data, qa, pa);
    model_edge(3, b_rst, b_flush, b_vld, b_rdy, b_data, qb, pb);
    if (pb) b_pushed++;
    #1;
    check_outputs();
  endtask

  task automatic drive_a(input logic vld, input logic [DW-1:0] d, input logic rdy);
    a_vld = vld; a_data = d; a_rdy = rdy;
  endtask

  initial begin
    a_rst = 1; a_flush = 0; a_vld = 1; a_rdy = 0; a_data = DW'(8'h77);
    b_rst = 1; b_flush = 0; b_vld = 1; b_rdy = 0; b_data = DW'(8'h66);
    #2;
    // Reset with I_VALID high: nothing is captured.
    repeat (2) cycle();
    check("rst_a_ready", DW'(a_ordy), DW'(1));
    check("rst_a_data", a_odata, '0);
    a_rst = 0; b_rst = 0; b_vld = 0;
    drive_a(0, '0, 1);
    cycle();
    check("idle_a_count", DW'(a_cnt), DW'(0));

    // Streaming at full rate.
    for (int i = 1; i <= 3; i++) begin
      drive_a(1, DW'(i), 1);
      cycle();
      check("stream_data", a_odata, DW'(i));
      check("stream_cnt_le1", DW'(a_cnt <= 2'd1), DW'(1));
    end
    drive_a(0, '0, 1);
    repeat (2) cycle();

    // Fill and stall.
    drive_a(1, DW'(8'hA), 0); cycle();
    drive_a(1, DW'(8'hB), 0); cycle();
    check("fill_count", DW'(a_cnt), DW'(2));
    check("fill_ready", DW'(a_ordy), DW'(0));
    drive_a(1, DW'(8'hC), 0); cycle();
    check("stall_hold", a_odata, DW'(8'hA));
    // Full with concurrent pop: C refused this cycle.
    drive_a(1, DW'(8'hC), 1); cycle();
    check("full_pop_count", DW'(a_cnt), DW'(1));
    check("full_pop_head", a_odata, DW'(8'hB));
    cycle();
    check("c_accepted", a_odata, DW'(8'hC));
    drive_a(0, '0, 1);
    repeat (2) cycle();

    // Flush mid-stream with a concurrent push of 0x55.
    drive_a(1, DW'(8'h11), 0); cycle();
    drive_a(1, DW'(8'h22), 0); cycle();
    drive_a(1, DW'(8'h55), 1); a_flush = 1; cycle();
    a_flush = 0;
    check("flush_count", DW'(a_cnt), DW'(0));
    check("flush_valid", DW'(a_ovld), DW'(0));
    check("flush_data", a_odata, '0);
    drive_a(0, '0, 1);
    repeat (3) cycle();

    // Random traffic on A, with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      drive_a(1'($urandom_range(0, 1)), rand_data(), 1'($urandom_range(0, 1)));
      a_flush = ($urandom_range(0, 15) == 0);
      a_rst   = ($urandom_range(0, 63) == 0);
      cycle();
    end
    a_flush = 0; a_rst = 0;
    drive_a(0, '0, 1);
    repeat (3) cycle();

    // DEPTH=3: ten distinct values with random back-pressure, wrapping the pointers.
    b_seen.delete();
    b_pushed = 0;
    for (int i = 0; i < 300 && (b_pushed < 10 || qb.size() != 0); i++) begin
      b_vld  = (b_pushed < 10) && ($urandom_range(0, 3) != 0);
      b_data = DW'(b_pushed + 1);
      b_rdy  = ($urandom_range(0, 2) == 0);
      cycle();
    end
    b_vld = 0;
    check("b_all_pushed", DW'(b_pushed), DW'(10));
    check("b_seen_count", DW'(b_seen.size()), DW'(10));
    for (int i = 0; i < b_seen.size() && i < 10; i++) check("b_order", b_seen[i], DW'(i + 1));

    // Further random traffic on B.
    for (int i = 0; i < 300; i++) begin
      b_vld   = 1'($urandom_range(0, 1));
      b_data  = rand_data();
      b_rdy   = 1'($urandom_range(0, 1));
      b_flush = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
